// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared constants and helpers for the SoC Avalon bus fabric.
//   AvlDataW  - Avalon read/write data width.
//   addr_w()  - word address width left over after the slave-select bits.
//   rr_next() - round-robin pointer increment with wrap at n-1 -> 0.
package soc_bus_pkg;

   localparam int unsigned AvlDataW = 32;

   // Byte addresses are 32 bits; the word address drops 2 LSBs and the select bits.
   function automatic int unsigned addr_w(input int unsigned sel_bits);
      return 30 - sel_bits;
   endfunction

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr >= n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search.
//   req    - request vector, one bit per requester.
//   ptr    - current priority pointer (highest-priority index).
//   winner - first requesting index at or above ptr, wrapping to 0.
//   found  - at least one request is present.
// winner is 0 when no request is present.
module rr_picker #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               found
);

   logic [IDX_W-1:0] win_hi;
   logic [IDX_W-1:0] win_lo;
   logic             found_hi;

   // Two searches: lowest request at or above ptr, and lowest request overall.
   // The second one is the wrapped-around winner when nothing sits above ptr.
   always_comb begin
      win_hi   = '0;
      win_lo   = '0;
      found_hi = 1'b0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         if (req[k]) begin
            win_lo = IDX_W'(k);
            if (IDX_W'(k) >= ptr) begin
               win_hi   = IDX_W'(k);
               found_hi = 1'b1;
            end
         end
      end
      found  = |req;
      winner = found_hi ? win_hi : win_lo;
   end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin arbiter sharing one boot-ROM read port among
// NUM_MASTERS Avalon read masters.
//   i_Clk, i_Rst_n      - clock, asynchronous active-low reset.
//   i_M_SlaveSel/Read   - per-master request qualifiers.
//   i_M_RegAddr         - packed per-master word addresses (AW bits each).
//   o_M_WaitRequest     - per-master hold-off, combinational from requests.
//   o_M_ReadData/Valid  - per-master read response, one cycle after accept.
//   o_S_*               - request to the ROM, driven by the current winner.
//   i_S_ReadData        - ROM data, valid the cycle after an accepted read.
//   i_S_WaitRequest     - ROM stall.
// Grant is zero-latency; only the response tag is registered.
module rom_port_arbiter
   import soc_bus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS   = 3,
   parameter int unsigned ADDR_SEL_BITS = 6,
   parameter int unsigned IDX_W         = $clog2(NUM_MASTERS),
   localparam int unsigned AW           = addr_w(ADDR_SEL_BITS)
) (
   input  logic                            i_Clk,
   input  logic                            i_Rst_n,
   input  logic [NUM_MASTERS-1:0]          i_M_SlaveSel,
   input  logic [NUM_MASTERS-1:0]          i_M_Read,
   input  logic [NUM_MASTERS*AW-1:0]       i_M_RegAddr,
   output logic [NUM_MASTERS-1:0]          o_M_WaitRequest,
   output logic [NUM_MASTERS*AvlDataW-1:0] o_M_ReadData,
   output logic [NUM_MASTERS-1:0]          o_M_ReadDataValid,
   output logic                            o_S_SlaveSel,
   output logic                            o_S_Read,
   output logic [AW-1:0]                   o_S_RegAddr,
   input  logic [AvlDataW-1:0]             i_S_ReadData,
   input  logic                            i_S_WaitRequest
);

   logic [NUM_MASTERS-1:0] req;
   logic [IDX_W-1:0]       winner;
   logic                   found;
   logic                   accept;

   logic [IDX_W-1:0]       ptr;
   logic                   rsp_v;
   logic [IDX_W-1:0]       rsp_idx;

   assign req    = i_M_SlaveSel & i_M_Read;
   assign accept = found & ~i_S_WaitRequest;

   rr_picker #(
      .NUM_REQ (NUM_MASTERS),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr),
      .winner (winner),
      .found  (found)
   );

   // Winner passes straight through; the ROM sees all zeros when idle.
   always_comb begin
      o_S_SlaveSel    = found;
      o_S_Read        = found;
      o_S_RegAddr     = '0;
      o_M_WaitRequest = '0;
      for (int k = 0; k < int'(NUM_MASTERS); k++) begin
         if (found && winner == IDX_W'(k)) begin
            o_S_RegAddr = i_M_RegAddr[k*AW +: AW];
         end
         o_M_WaitRequest[k] = req[k] & ~(accept & (winner == IDX_W'(k)));
      end
   end

   // Pointer freezes during a ROM stall so the same master is re-selected.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         ptr     <= '0;
         rsp_v   <= 1'b0;
         rsp_idx <= '0;
      end else begin
         if (accept) begin
            ptr <= IDX_W'(rr_next(32'(winner), NUM_MASTERS));
         end
         rsp_v   <= accept;
         rsp_idx <= winner;
      end
   end

   // Steer the ROM's registered data to the master tagged last cycle.
   always_comb begin
      o_M_ReadDataValid = '0;
      o_M_ReadData      = '0;
      for (int k = 0; k < int'(NUM_MASTERS); k++) begin
         if (rsp_v && rsp_idx == IDX_W'(k)) begin
            o_M_ReadDataValid[k]                  = 1'b1;
            o_M_ReadData[k*AvlDataW +: AvlDataW] = i_S_ReadData;
         end
      end
   end

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 24;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    m_sel = '0;
   logic [N-1:0]    m_rd = '0;
   logic [N*AW-1:0] m_addr = '0;
   logic [N-1:0]    m_wait;
   logic [N*32-1:0] m_data;
   logic [N-1:0]    m_valid;
   logic            s_sel;
   logic            s_read;
   logic [AW-1:0]   s_addr;
   logic [31:0]     s_rdata = '0;
   logic            s_wait = 1'b0;

   always #5 clk = ~clk;

   rom_port_arbiter #(
      .NUM_MASTERS   (N),
      .ADDR_SEL_BITS (6)
   ) dut (
      .i_Clk             (clk),
      .i_Rst_n           (rst_n),
      .i_M_SlaveSel      (m_sel),
      .i_M_Read          (m_rd),
      .i_M_RegAddr       (m_addr),
      .o_M_WaitRequest   (m_wait),
      .o_M_ReadData      (m_data),
      .o_M_ReadDataValid (m_valid),
      .o_S_SlaveSel      (s_sel),
      .o_S_Read          (s_read),
      .o_S_RegAddr       (s_addr),
      .i_S_ReadData      (s_rdata),
      .i_S_WaitRequest   (s_wait)
   );

   // Boot ROM contents; unlisted words get a scrambled pattern.
   function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
      case (a)
         24'd0:   return 32'h00000317;
         24'd1:   return 32'h0a430313;
         24'd2:   return 32'h00032403;
         24'd5:   return 32'h00b62223;
         default: return ({8'h0, a} * 32'h9e3779b9) ^ 32'h00005a5a;
      endcase
   endfunction

   // ROM emulation: registered read, garbage on the bus when no read was accepted.
   always @(posedge clk) begin
      if (s_read && s_sel && !s_wait) s_rdata <= rom_word(s_addr);
      else                            s_rdata <= $urandom;
   end

   int vectors = 0;
   int miscompares = 0;

   // Reference model state.
   int            m_ptr = 0;
   bit            m_rsp_v = 0;
   int            m_rsp_idx = 0;
   logic [AW-1:0] m_rsp_addr = '0;
   bit            m_found, m_accept;
   int            m_winner;
   logic [N-1:0]    exp_wait, exp_valid;
   logic [N*32-1:0] exp_data;
   logic            exp_sel, exp_read;
   logic [AW-1:0]   exp_addr;

   task automatic model_reset();
      m_ptr = 0;
      m_rsp_v = 0;
      m_rsp_idx = 0;
   endtask

   task automatic model_comb();
      int idx;
      m_found = 0;
      m_winner = 0;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (!m_found && m_sel[idx] && m_rd[idx]) begin
            m_found = 1;
            m_winner = idx;
         end
      end
      m_accept = m_found && !s_wait;
      exp_sel  = m_found;
      exp_read = m_found;
      exp_addr = m_found ? m_addr[m_winner*AW +: AW] : '0;
      for (int k = 0; k < N; k++)
         exp_wait[k] = m_sel[k] && m_rd[k] && !(m_accept && m_winner == k);
      exp_valid = '0;
      exp_data  = '0;
      if (m_rsp_v) begin
         exp_valid[m_rsp_idx] = 1'b1;
         exp_data[m_rsp_idx*32 +: 32] = rom_word(m_rsp_addr);
      end
   endtask

   task automatic model_clock();
      if (!rst_n) begin
         model_reset();
      end else if (m_accept) begin
         m_rsp_v = 1;
         m_rsp_idx = m_winner;
         m_rsp_addr = exp_addr;
         m_ptr = (m_winner + 1) % N;
      end else begin
         m_rsp_v = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
   endtask

   task automatic drive_idle();
      m_sel = '0;
      m_rd = '0;
      m_addr = '0;
      s_wait = 1'b0;
   endtask

   task automatic req_master(input int k, input logic [AW-1:0] a);
      m_sel[k] = 1'b1;
      m_rd[k] = 1'b1;
      m_addr[k*AW +: AW] = a;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      #1 model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         drive_idle();
         rst_n = (c >= 2);
         if (c == 1) req_master(2, 24'd7);
         #1 model_comb();
         vectors += 4;
         if (m_wait !== exp_wait) begin
            miscompares++;
            $display("FAIL reset c%0d waitrequest: got %b want %b", c, m_wait, exp_wait);
         end
         if ({s_sel, s_read, s_addr} !== {exp_sel, exp_read, exp_addr}) begin
            miscompares++;
            $display("FAIL reset c%0d rom_req: got %b/%b/%h want %b/%b/%h", c, s_sel, s_read,
                     s_addr, exp_sel, exp_read, exp_addr);
         end
         if (m_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL reset c%0d valid: got %b want %b", c, m_valid, exp_valid);
         end
         if (m_data !== exp_data) begin
            miscompares++;
            $display("FAIL reset c%0d data: got %h want %h", c, m_data, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive_idle();
         if (c == 0) req_master(1, 24'd5);
         #1 model_comb();
         vectors += 4;
         if (m_wait !== exp_wait) begin
            miscompares++;
            $display("FAIL single c%0d waitrequest: got %b want %b", c, m_wait, exp_wait);
         end
         if ({s_sel, s_read, s_addr} !== {exp_sel, exp_read, exp_addr}) begin
            miscompares++;
            $display("FAIL single c%0d rom_req: got %h want %h", c, s_addr, exp_addr);
         end
         if (m_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL single c%0d valid: got %b want %b", c, m_valid, exp_valid);
         end
         if (m_data !== exp_data) begin
            miscompares++;
            $display("FAIL single c%0d data: got %h want %h", c, m_data, exp_data);
         end
         if (c == 1) begin
            vectors += 2;
            if (m_valid !== 3'b010) begin
               miscompares++;
               $display("FAIL single valid1: got %b want 010", m_valid);
            end
            if (m_data[63:32] !== 32'h00b62223) begin
               miscompares++;
               $display("FAIL single word5: got %h want 00b62223", m_data[63:32]);
            end
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         drive_idle();
         if (c < 7) for (int k = 0; k < N; k++) req_master(k, AW'(k));
         #1 model_comb();
         vectors += 4;
         if (m_wait !== exp_wait) begin
            miscompares++;
            $display("FAIL rr c%0d waitrequest: got %b want %b", c, m_wait, exp_wait);
         end
         if ({s_sel, s_read, s_addr} !== {exp_sel, exp_read, exp_addr}) begin
            miscompares++;
            $display("FAIL rr c%0d rom_req: got %h want %h", c, s_addr, exp_addr);
         end
         if (m_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL rr c%0d valid: got %b want %b", c, m_valid, exp_valid);
         end
         if (m_data !== exp_data) begin
            miscompares++;
            $display("FAIL rr c%0d data: got %h want %h", c, m_data, exp_data);
         end
         if (c < 7) begin
            vectors++;
            if (s_addr !== AW'(c % 3)) begin
               miscompares++;
               $display("FAIL rr c%0d grant: got %0d want %0d", c, s_addr, c % 3);
            end
         end
         if (c >= 1) begin
            vectors++;
            if (m_valid !== N'(1 << ((c - 1) % 3))) begin
               miscompares++;
               $display("FAIL rr c%0d valid_seq: got %b want %0d", c, m_valid, (c - 1) % 3);
            end
         end
         tick();
      end
   endtask

   task automatic test_priority();
      int wait0 = 0;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive_idle();
         if (c == 0) req_master(0, 24'd3);
         if (c == 1) begin
            req_master(0, 24'd10);
            req_master(2, 24'd20);
         end
         if (c == 2) req_master(0, 24'd10);
         #1 model_comb();
         if (m_wait[0] === 1'b1) wait0++;
         vectors += 4;
         if (m_wait !== exp_wait) begin
            miscompares++;
            $display("FAIL prio c%0d waitrequest: got %b want %b", c, m_wait, exp_wait);
         end
         if ({s_sel, s_read, s_addr} !== {exp_sel, exp_read, exp_addr}) begin
            miscompares++;
            $display("FAIL prio c%0d rom_req: got %h want %h", c, s_addr, exp_addr);
         end
         if (m_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL prio c%0d valid: got %b want %b", c, m_valid, exp_valid);
         end
         if (m_data !== exp_data) begin
            miscompares++;
            $display("FAIL prio c%0d data: got %h want %h", c, m_data, exp_data);
         end
         if (c == 1 || c == 2) begin
            vectors++;
            if (s_addr !== ((c == 1) ? 24'd20 : 24'd10)) begin
               miscompares++;
               $display("FAIL prio c%0d winner_addr: got %0d", c, s_addr);
            end
         end
         tick();
      end
      vectors++;
      if (wait0 != 1) begin
         miscompares++;
         $display("FAIL prio wait0_cycles: got %0d want 1", wait0);
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         drive_idle();
         if (c == 0) req_master(0, 24'd4);
         if (c >= 1 && c <= 4) begin
            req_master(1, 24'd6);
            req_master(2, 24'd8);
         end
         if (c == 5) req_master(2, 24'd8);
         s_wait = (c >= 1 && c <= 3);
         #1 model_comb();
         vectors += 4;
         if (m_wait !== exp_wait) begin
            miscompares++;
            $display("FAIL stall c%0d waitrequest: got %b want %b", c, m_wait, exp_wait);
         end
         if ({s_sel, s_read, s_addr} !== {exp_sel, exp_read, exp_addr}) begin
            miscompares++;
            $display("FAIL stall c%0d rom_req: got %h want %h", c, s_addr, exp_addr);
         end
         if (m_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL stall c%0d valid: got %b want %b", c, m_valid, exp_valid);
         end
         if (m_data !== exp_data) begin
            miscompares++;
            $display("FAIL stall c%0d data: got %h want %h", c, m_data, exp_data);
         end
         if (c >= 2 && c <= 4) begin
            vectors++;
            if (m_valid !== 3'b000) begin
               miscompares++;
               $display("FAIL stall c%0d no_valid: got %b want 000", c, m_valid);
            end
         end
         if (c == 4) begin
            vectors++;
            if (s_addr !== 24'd6 || m_wait !== 3'b100) begin
               miscompares++;
               $display("FAIL stall post_grant: got addr %0d wait %b want 6 100", s_addr, m_wait);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      drive_idle();
      req_master(0, 24'd2);
      #1 model_comb();
      tick();
      #1;
      vectors++;
      if (m_valid !== 3'b001) begin
         miscompares++;
         $display("FAIL rstmid pre_valid: got %b want 001", m_valid);
      end
      rst_n = 1'b0;
      drive_idle();
      #1 model_reset();
      vectors += 2;
      if (m_valid !== 3'b000) begin
         miscompares++;
         $display("FAIL rstmid valid_drop: got %b want 000", m_valid);
      end
      if (m_data !== '0) begin
         miscompares++;
         $display("FAIL rstmid data_drop: got %h want 0", m_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1 model_comb();
         vectors += 2;
         if (m_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL rstmid c%0d valid: got %b want %b", c, m_valid, exp_valid);
         end
         if (m_data !== exp_data) begin
            miscompares++;
            $display("FAIL rstmid c%0d data: got %h want %h", c, m_data, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [N-1:0] hold = '0;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         // A held-off master keeps its request and address unchanged.
         for (int k = 0; k < N; k++) begin
            if (!hold[k]) begin
               m_sel[k] = ($urandom_range(0, 3) != 0);
               m_rd[k]  = ($urandom_range(0, 2) != 0);
               m_addr[k*AW +: AW] = AW'($urandom_range(0, 63));
            end
         end
         s_wait = ($urandom_range(0, 4) == 0);
         #1 model_comb();
         hold = exp_wait;
         vectors += 4;
         if (m_wait !== exp_wait) begin
            miscompares++;
            $display("FAIL rand c%0d waitrequest: got %b want %b", c, m_wait, exp_wait);
         end
         if ({s_sel, s_read, s_addr} !== {exp_sel, exp_read, exp_addr}) begin
            miscompares++;
            $display("FAIL rand c%0d rom_req: got %b/%b/%h want %b/%b/%h", c, s_sel, s_read,
                     s_addr, exp_sel, exp_read, exp_addr);
         end
         if (m_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL rand c%0d valid: got %b want %b", c, m_valid, exp_valid);
         end
         if (m_data !== exp_data) begin
            miscompares++;
            $display("FAIL rand c%0d data: got %h want %h", c, m_data, exp_data);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_priority();
      test_stall();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
